// File: rtl/rgb2bayer_if.sv
// rgb2bayer_if: groups the RGB input stream and the Bayer output stream
// of rgb2bayer.
// The line_err/frame_err signals exist only when RGB2BAYER_ERR_EN is defined.
interface rgb2bayer_if;
    logic        rgb_hsync;
    logic        rgb_vsync;
    logic        rgb_de;
    logic [23:0] rgb_data;
    logic        bayer_hsync;
    logic        bayer_vsync;
    logic        bayer_de;
    logic [7:0]  bayer_data;
`ifdef RGB2BAYER_ERR_EN
    logic        line_err;
    logic        frame_err;
`endif

    // Video source side: drives RGB, observes Bayer.
    modport master (
        output rgb_hsync, output rgb_vsync, output rgb_de, output rgb_data,
        input  bayer_hsync, input bayer_vsync, input bayer_de, input bayer_data
`ifdef RGB2BAYER_ERR_EN
        , input line_err, input frame_err
`endif
    );

    // Converter side: consumes RGB, produces Bayer.
    modport slave (
        input  rgb_hsync, input rgb_vsync, input rgb_de, input rgb_data,
        output bayer_hsync, output bayer_vsync, output bayer_de, output bayer_data
`ifdef RGB2BAYER_ERR_EN
        , output line_err, output frame_err
`endif
    );
endinterface

// File: rtl/rgb2bayer.sv
// rgb2bayer: re-mosaics an RGB888 stream into an 8-bit Bayer stream.
// Each pixel keeps the one component that the CFA pattern assigns to its
// {row[0], col[0]} position. Syncs and data share a fixed 2-clk latency.
// Optional macro RGB2BAYER_ERR_EN adds line_err/frame_err pulse outputs.
module rgb2bayer #(
    parameter logic [11:0] H_DISP        = 12'd640,
    parameter logic [11:0] V_DISP        = 12'd480,
    parameter logic [1:0]  BAYER_PATTERN = 2'd3    // 0=GRBG 1=RGGB 2=BGGR 3=GBRG
) (
    input  logic         clk,
    input  logic         rst,
    rgb2bayer_if.slave   bus
);

    // Pick the CFA component for a position code {row[0], col[0]}.
    function automatic logic [7:0] sel_comp(input logic [1:0] code, input logic [23:0] px);
        logic [7:0] r, g, b;
        logic [7:0] res;
        r = px[23:16];
        g = px[15:8];
        b = px[7:0];
        res = g;
        case (BAYER_PATTERN)
            2'd0: case (code) 2'b00: res = g; 2'b01: res = r; 2'b10: res = b; default: res = g; endcase
            2'd1: case (code) 2'b00: res = r; 2'b01: res = g; 2'b10: res = g; default: res = b; endcase
            2'd2: case (code) 2'b00: res = b; 2'b01: res = g; 2'b10: res = g; default: res = r; endcase
            default: case (code) 2'b00: res = g; 2'b01: res = b; 2'b10: res = r; default: res = g; endcase
        endcase
        return res;
    endfunction

    // Row advance with wrap at the end of the frame.
    function automatic logic [11:0] row_next(input logic [11:0] r);
        return (r == V_DISP - 12'd1) ? 12'd0 : r + 12'd1;
    endfunction

    logic        vs_prev_q, de_prev_q;
    logic [11:0] col_q, col_d;
    logic [11:0] row_q, row_d;
    logic        vs_rise, de_fall, short_line;

    logic [23:0] data_p1_q;
    logic        hs_p1_q, vs_p1_q, vld_p1_q;
    logic [1:0]  pos_p1_q;

    logic [7:0]  data_p2_q;
    logic        hs_p2_q, vs_p2_q, vld_p2_q;

    assign vs_rise    = bus.rgb_vsync & ~vs_prev_q;
    assign de_fall    = ~bus.rgb_de & de_prev_q;
    assign short_line = de_fall & (col_q != 12'd0);

    // Position counters: vsync rise clears, de advances, short-line de fall wraps.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (vs_rise) begin
            col_d = 12'd0;
            row_d = 12'd0;
        end else if (bus.rgb_de) begin
            if (col_q == H_DISP - 12'd1) begin
                col_d = 12'd0;
                row_d = row_next(row_q);
            end else begin
                col_d = col_q + 12'd1;
            end
        end else if (short_line) begin
            col_d = 12'd0;
            row_d = row_next(row_q);
        end
    end

    // ---- stage 1: capture pixel, syncs and pre-update position ----
    // Stage 1 register plus counter/edge-detect state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            col_q     <= 12'd0;
            row_q     <= 12'd0;
            data_p1_q <= 24'd0;
            hs_p1_q   <= 1'b0;
            vs_p1_q   <= 1'b0;
            vld_p1_q  <= 1'b0;
            pos_p1_q  <= 2'b00;
        end else begin
            vs_prev_q <= bus.rgb_vsync;
            de_prev_q <= bus.rgb_de;
            col_q     <= col_d;
            row_q     <= row_d;
            data_p1_q <= bus.rgb_data;
            hs_p1_q   <= bus.rgb_hsync;
            vs_p1_q   <= bus.rgb_vsync;
            vld_p1_q  <= bus.rgb_de;
            pos_p1_q  <= {row_q[0], col_q[0]};
        end
    end

    // ---- stage 2: component select, blanked to zero outside de ----
    // Stage 2 register driving the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p2_q <= 8'd0;
            hs_p2_q   <= 1'b0;
            vs_p2_q   <= 1'b0;
            vld_p2_q  <= 1'b0;
        end else begin
            data_p2_q <= vld_p1_q ? sel_comp(pos_p1_q, data_p1_q) : 8'd0;
            hs_p2_q   <= hs_p1_q;
            vs_p2_q   <= vs_p1_q;
            vld_p2_q  <= vld_p1_q;
        end
    end

    assign bus.bayer_hsync = hs_p2_q;
    assign bus.bayer_vsync = vs_p2_q;
    assign bus.bayer_de    = vld_p2_q;
    assign bus.bayer_data  = data_p2_q;

`ifdef RGB2BAYER_ERR_EN
    logic seen_vs_q;
    logic lerr_p1_q, ferr_p1_q;
    logic lerr_p2_q, ferr_p2_q;

    // Error pulses travel the same two stages as the pixel stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_vs_q <= 1'b0;
            lerr_p1_q <= 1'b0;
            ferr_p1_q <= 1'b0;
            lerr_p2_q <= 1'b0;
            ferr_p2_q <= 1'b0;
        end else begin
            seen_vs_q <= seen_vs_q | vs_rise;
            lerr_p1_q <= short_line;
            // The first vsync after reset has no preceding frame to judge.
            ferr_p1_q <= vs_rise & seen_vs_q & ((row_q != 12'd0) | (col_q != 12'd0));
            lerr_p2_q <= lerr_p1_q;
            ferr_p2_q <= ferr_p1_q;
        end
    end

    assign bus.line_err  = lerr_p2_q;
    assign bus.frame_err = ferr_p2_q;
`endif

endmodule

// File: tb/tb_rgb2bayer.sv
// tb_rgb2bayer: scoreboard bench for rgb2bayer. Four DUTs (one per CFA
// pattern, H_DISP=8, V_DISP=4) share one randomised/directed RGB stream.
// A reference model pushes expected outputs; a monitor pops and compares.
module tb_rgb2bayer;
    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst_s = 1'b1;
    logic        hs_s = 1'b0, vs_s = 1'b0, de_s = 1'b0;
    logic [23:0] d_s = 24'd0;
    int          cyc = 0;

    // Observed per-DUT vector {line_err, frame_err, hsync, vsync, de, data}.
    logic [12:0] act [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rgb2bayer_if bif ();
        assign bif.rgb_hsync = hs_s;
        assign bif.rgb_vsync = vs_s;
        assign bif.rgb_de    = de_s;
        assign bif.rgb_data  = d_s;
        rgb2bayer #(.H_DISP(12'd8), .V_DISP(12'd4), .BAYER_PATTERN(2'(g))) u_dut (
            .clk (clk),
            .rst (rst_s),
            .bus (bif.slave)
        );
`ifdef RGB2BAYER_ERR_EN
        assign act[g] = {bif.line_err, bif.frame_err, bif.bayer_hsync, bif.bayer_vsync,
                         bif.bayer_de, bif.bayer_data};
`else
        assign act[g] = {2'b00, bif.bayer_hsync, bif.bayer_vsync, bif.bayer_de, bif.bayer_data};
`endif
    end

    typedef struct {
        int              due;
        logic [3:0][12:0] o;
    } exp_t;
    exp_t exp_q[$];

    int nchk = 0;
    int nfail = 0;

    // Reference model state (spec-level: row/column position, previous syncs).
    string pat [4] = '{"GRBG", "RGGB", "BGGR", "GBRG"};
    int    mrow = 0, mcol = 0;
    bit    mvs_p = 0, mde_p = 0, mseen = 0;

    function automatic logic [7:0] pick(input int p, input int row, input int col,
                                        input logic [23:0] px);
        byte c;
        c = pat[p].getc((row % 2) * 2 + (col % 2));
        if (c == "R") return px[23:16];
        if (c == "G") return px[15:8];
        return px[7:0];
    endfunction

    // Apply one input cycle to the model and queue the output due 2 clk later.
    task automatic cycle(input logic r, input logic hs, input logic vs, input logic de,
                         input logic [23:0] d);
        exp_t e;
        bit   le, fe;
        @(posedge clk);
        #1;
        rst_s = r; hs_s = hs; vs_s = vs; de_s = de; d_s = d;
        e.due = cyc + 2;
        e.o   = '0;
        if (r) begin
            foreach (exp_q[i]) if (exp_q[i].due == cyc + 1) exp_q[i].o = '0;
            mrow = 0; mcol = 0; mvs_p = 0; mde_p = 0; mseen = 0;
        end else begin
            le = !de && mde_p && (mcol != 0);
            fe = vs && !mvs_p && mseen && (mrow != 0 || mcol != 0);
`ifndef RGB2BAYER_ERR_EN
            le = 0; fe = 0;
`endif
            for (int p = 0; p < 4; p++)
                e.o[p] = {le, fe, hs, vs, de, de ? pick(p, mrow, mcol, d) : 8'h00};
            if (vs && !mvs_p) begin
                mseen = 1; mrow = 0; mcol = 0;
            end else if (de) begin
                mcol++;
                if (mcol == H) begin mcol = 0; mrow = (mrow + 1) % V; end
            end else if (mde_p && mcol != 0) begin
                mcol = 0; mrow = (mrow + 1) % V;
            end
            mvs_p = vs; mde_p = de;
        end
        exp_q.push_back(e);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 1, {8'h10 + 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)});
        cycle(0, 1, 0, 0, 24'hFFFFFF);
        cycle(0, 1, 0, 0, 24'hFFFFFF);
        cycle(0, 0, 0, 0, 24'hFFFFFF);
    endtask

    task automatic vpulse();
        cycle(0, 0, 1, 0, 24'hFFFFFF);
        cycle(0, 0, 1, 0, 24'hFFFFFF);
        cycle(0, 0, 0, 0, 24'hFFFFFF);
    endtask

    // Monitor: every clk the DUTs present a sample; compare it with the queue head.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
                nchk++; nfail++;
                $display("FAIL missed_sample due=%0d now=%0d", e.due, cyc);
            end else begin
                for (int p = 0; p < 4; p++) begin
                    nchk++;
                    if (act[p] !== e.o[p]) begin
                        nfail++;
                        $display("FAIL out_pat%0d cyc=%0d got=%h exp=%h", p, cyc, act[p], e.o[p]);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        // Reset state, then blanking with all-ones data.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 24'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 24'hFFFFFF);
        // First vsync, then a complete 4-line frame.
        vpulse();
        for (int l = 0; l < V; l++) line(H);
        vpulse();
        // Short line followed by a full line.
        line(5);
        line(H);
        // Mid-frame vsync at row 2, col 3, arriving with the de fall.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, {8'h20 + 8'(i), 8'h50 + 8'(i), 8'h90 + 8'(i)});
        cycle(0, 0, 1, 0, 24'hFFFFFF);
        cycle(0, 0, 0, 0, 24'hFFFFFF);
        line(H);
        // Long line wraps at H.
        line(H + 4);
        // Reset for one clk mid-line.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 24'h123456 + 24'(i));
        cycle(1, 0, 0, 1, 24'hABCDEF);
        line(H);
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic de, vs, hs, r;
            de = ($urandom_range(0, 9) < 7);
            vs = ($urandom_range(0, 49) == 0);
            hs = $urandom_range(0, 1);
            r  = ($urandom_range(0, 299) == 0);
            cycle(r, hs, vs, de, 24'($urandom));
        end
        // Drain with a bounded wait.
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            nchk++; nfail++;
            $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
